// File: rtl/axi_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle between one master and the register-file responder.
//   master modport: drives AW/W/AR payload+valid and B/R ready.
//   slave  modport: drives AW/W/AR ready and B/R response+valid.
// Clock and reset are not part of the bundle; they stay plain module ports.
interface axi_lite_regfile_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite responder backed by NUM_REGS bus-wide registers.
// Ports:
//   aclk      - clock, rising edge
//   areset_n  - asynchronous active-low reset
//   s         - AXI4-Lite slave bundle (AW, W, B, AR, R channels)
// Write and read channels have independent FSMs. Writes are byte-strobed;
// addresses beyond the bank answer SLVERR without touching any register.
// DATA_WIDTH is expected to be 32 or 64.
module axi_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    axi_lite_regfile_slave_if.slave  s
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_RESP} rstate_e;

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a >> ADDR_LSB) >= ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_LSB +: IDX_W];
    endfunction

    // Register bank
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

    // Readies are held low until the first edge after reset release, so the
    // reset-state FSMs (which decode to "ready") cannot show through early.
    logic rdy_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) rdy_q <= 1'b0;
        else           rdy_q <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_e               wst_q, wst_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            bresp_q;
    logic                  awready, wready, bvalid;
    logic                  aw_hs, w_hs, b_hs, wr_commit;

    // The half that arrived first comes from its latch, the other is live.
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;
    logic                  c_err;
    logic [IDX_W-1:0]      c_idx;

    assign aw_hs  = s.awvalid & awready;
    assign w_hs   = s.wvalid & wready;
    assign b_hs   = bvalid & s.bready;
    assign c_addr = (wst_q == W_GOT_AW) ? awaddr_q : s.awaddr;
    assign c_data = (wst_q == W_GOT_W)  ? wdata_q  : s.wdata;
    assign c_strb = (wst_q == W_GOT_W)  ? wstrb_q  : s.wstrb;
    assign c_err  = addr_err(c_addr);
    assign c_idx  = addr_idx(c_addr);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) wst_q <= W_IDLE;
        else           wst_q <= wst_d;
    end

    always_comb begin
        wst_d     = wst_q;
        wr_commit = 1'b0;
        case (wst_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wst_d     = W_RESP;
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    wst_d = W_GOT_AW;
                end else if (w_hs) begin
                    wst_d = W_GOT_W;
                end
            end
            W_GOT_AW: if (w_hs) begin
                wst_d     = W_RESP;
                wr_commit = 1'b1;
            end
            W_GOT_W: if (aw_hs) begin
                wst_d     = W_RESP;
                wr_commit = 1'b1;
            end
            W_RESP: if (b_hs) wst_d = W_IDLE;
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wst_q)
            W_IDLE:   begin awready = rdy_q; wready = rdy_q; end
            W_GOT_AW: wready  = rdy_q;
            W_GOT_W:  awready = rdy_q;
            W_RESP:   bvalid  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) awaddr_q <= s.awaddr;
            if (w_hs) begin
                wdata_q <= s.wdata;
                wstrb_q <= s.wstrb;
            end
            if (wr_commit) bresp_q <= c_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            regs_q <= '0;
        end else if (wr_commit && !c_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (c_strb[b]) regs_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_e               rst_q, rst_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  arready, rvalid, ar_hs, r_hs;
    logic                  r_err;
    logic [IDX_W-1:0]      r_idx;

    assign ar_hs = s.arvalid & arready;
    assign r_hs  = rvalid & s.rready;
    assign r_err = addr_err(s.araddr);
    assign r_idx = addr_idx(s.araddr);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) rst_q <= R_IDLE;
        else           rst_q <= rst_d;
    end

    always_comb begin
        rst_d = rst_q;
        case (rst_q)
            R_IDLE:  if (ar_hs) rst_d = R_RESP;
            R_RESP:  if (r_hs)  rst_d = R_IDLE;
            default: rst_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rst_q)
            R_IDLE:  arready = rdy_q;
            R_RESP:  rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Sampling regs_q (not the write next-state) gives a same-edge read the
    // pre-write value.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= r_err ? '0 : regs_q[r_idx];
            rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign s.awready = awready;
    assign s.wready  = wready;
    assign s.bvalid  = bvalid;
    assign s.bresp   = bresp_q;
    assign s.arready = arready;
    assign s.rvalid  = rvalid;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
module tb_axi_lite_regfile_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    axi_lite_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .s        (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] model [NR];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] st,
                                logic [1:0] rs, logic [31:0] rd);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = st; v.resp = rs; v.rdata = rd;
        return v;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // AW and W presented together; bvalid expected exactly one cycle after.
    task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, input logic [1:0] exp_resp);
        int n;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = st;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
        chk({nm, ".aw_w_ready"}, {62'd0, bus.awready, bus.wready}, 64'd3);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk({nm, ".bvalid"}, 64'(bus.bvalid), 64'd1);
        chk({nm, ".bresp"}, 64'(bus.bresp), 64'(exp_resp));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk({nm, ".bvalid_clr"}, 64'(bus.bvalid), 64'd0);
        if (exp_resp == 2'b00) model[a[5:2]] = merge(model[a[5:2]], d, st);
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                      input logic [1:0] exp_resp);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin tick(); n++; end
        chk({nm, ".arready"}, 64'(bus.arready), 64'd1);
        tick();
        bus.arvalid = 1'b0;
        chk({nm, ".rvalid"}, 64'(bus.rvalid), 64'd1);
        chk({nm, ".rdata"}, 64'(bus.rdata), 64'(exp_d));
        chk({nm, ".rresp"}, 64'(bus.rresp), 64'(exp_resp));
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk({nm, ".rvalid_clr"}, 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
        vecs[1]  = mk(0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF);
        vecs[2]  = mk(1, 32'h00, 32'h01020304, 4'hF, 2'b00, 32'h0);
        vecs[3]  = mk(1, 32'h3C, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0);
        vecs[4]  = mk(0, 32'h3F, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D);
        vecs[5]  = mk(1, 32'h00, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0);
        vecs[6]  = mk(0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h01020304);
        vecs[7]  = mk(1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0);
        vecs[8]  = mk(0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0);
        vecs[9]  = mk(1, 32'h10, 32'hA5A5A5A5, 4'h8, 2'b00, 32'h0);
        vecs[10] = mk(0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hA5000000);
        vecs[11] = mk(0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF);
        vecs[12] = mk(1, 32'hFFFFFFFC, 32'h1,  4'hF, 2'b10, 32'h0);
        vecs[13] = mk(0, 32'h80000004, 32'h0,  4'h0, 2'b10, 32'h0);
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

        // Reset state
        #1;
        chk("rst.awready", 64'(bus.awready), 0);
        chk("rst.wready",  64'(bus.wready), 0);
        chk("rst.arready", 64'(bus.arready), 0);
        chk("rst.bvalid",  64'(bus.bvalid), 0);
        chk("rst.rvalid",  64'(bus.rvalid), 0);
        chk("rst.rdata",   64'(bus.rdata), 0);
        chk("rst.bresp",   64'(bus.bresp), 0);
        repeat (2) @(posedge aclk);
        #3 areset_n = 1'b1;
        #1 chk("rel.awready_pre", 64'(bus.awready), 0);
        tick();
        chk("rel.readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr)
                wr($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            else
                rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rdata, vecs[i].resp);
        end

        // W two cycles ahead of AW
        bus.wdata = 32'h11223344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        chk("wfirst.wready", 64'(bus.wready), 1);
        tick();
        bus.wvalid = 1'b0;
        chk("wfirst.wready_drop", 64'(bus.wready), 0);
        chk("wfirst.awready", 64'(bus.awready), 1);
        tick();
        chk("wfirst.no_bvalid", 64'(bus.bvalid), 0);
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("wfirst.bvalid", 64'(bus.bvalid), 1);
        chk("wfirst.bresp", 64'(bus.bresp), 0);
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;
        model[2] = 32'h11223344;
        rd("wfirst.rd", 32'h08, 32'h11223344, 2'b00);

        // Partial strobe merge
        wr("strb", 32'h08, 32'hAABBCCDD, 4'b0101, 2'b00);
        rd("strb.rd", 32'h08, 32'h11BB33DD, 2'b00);

        // Out-of-range write leaves whole bank intact
        wr("oor", 32'h40, 32'h87654321, 4'hF, 2'b10);
        for (int i = 0; i < NR; i++) rd($sformatf("bank%0d", i), 32'(i * 4), model[i], 2'b00);

        // AW first, then W, then held-off bready with competing AW/W offered
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("awfirst.awready", 64'(bus.awready), 0);
        chk("awfirst.wready", 64'(bus.wready), 1);
        bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awaddr = 32'h00; bus.awvalid = 1'b1; bus.wdata = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp.b%0d", c), {60'd0, bus.bvalid, bus.bresp, bus.awready},
                {60'd0, 1'b1, 2'b00, 1'b0});
            chk($sformatf("bp.wready%0d", c), 64'(bus.wready), 0);
            tick();
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;
        chk("bp.bclr", 64'(bus.bvalid), 0);
        model[3] = 32'h0BADF00D;

        // Read held off with rready low
        bus.araddr = 32'h0C; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rbp.r%0d", c), {29'd0, bus.rvalid, bus.rresp, bus.rdata, bus.arready},
                {29'd0, 1'b1, 2'b00, 32'h0BADF00D, 1'b0});
            tick();
        end
        bus.rready = 1'b1; tick(); bus.rready = 1'b0;
        chk("rbp.rclr", 64'(bus.rvalid), 0);

        // Read and write to reg0 committing on the same edge
        bus.awaddr = 32'h00; bus.wdata = 32'h55667788; bus.wstrb = 4'hF; bus.araddr = 32'h00;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("coll.valids", {62'd0, bus.bvalid, bus.rvalid}, 64'd3);
        chk("coll.rdata_old", 64'(bus.rdata), 64'h01020304);
        bus.bready = 1'b1; bus.rready = 1'b1; tick(); bus.bready = 1'b0; bus.rready = 1'b0;
        model[0] = 32'h55667788;
        rd("coll.rd_new", 32'h00, 32'h55667788, 2'b00);

        // Reset while a write response is pending
        bus.awaddr = 32'h14; bus.wdata = 32'h77777777; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("mrst.bvalid_pre", 64'(bus.bvalid), 1);
        #2 areset_n = 1'b0;
        #1;
        chk("mrst.bvalid", 64'(bus.bvalid), 0);
        chk("mrst.readies", {62'd0, bus.awready, bus.arready}, 0);
        @(posedge aclk);
        #3 areset_n = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        rd("mrst.rd14", 32'h14, 32'h0, 2'b00);
        rd("mrst.rd04", 32'h04, 32'h0, 2'b00);
        wr("mrst.wr", 32'h14, 32'h12121212, 4'hF, 2'b00);
        rd("mrst.rd_new", 32'h14, 32'h12121212, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
